lcd_ctrl_param: RTL and testbench

Parametrised image-window display controller, the next generation of the fixed 12x9 LCD controller. It loads an IMG_W x IMG_H pixel frame serially into internal storage, then streams a WIN x WIN view one pixel per cycle on every command. The view is either a fit (subsampled) view or a zoom (crop) view, with rotation in both modes and horizontal mirroring. It sits between the frame source and the LCD driver.

---
 rtl/lcd_ctrl_param_if.sv | 22 ++
 rtl/lcd_ctrl_param.sv | 187 ++++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_param_if.sv
// Command and pixel bus between the frame source, the LCD driver and lcd_ctrl_param.
// The master is the frame source/driver side; the slave is the controller.
interface lcd_ctrl_param_if #(
  parameter int DW = 8
);
  logic [DW-1:0] datain;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic [DW-1:0] dataout;
  logic          output_valid;

  modport master (
    output datain, cmd, cmd_valid,
    input  busy, dataout, output_valid
  );

  modport slave (
    input  datain, cmd, cmd_valid,
    output busy, dataout, output_valid
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Parametrised window display controller: loads an IMG_W x IMG_H frame, then streams a
// WIN x WIN fit or zoom view (rotated/mirrored) as one burst per command. reset is active-low.
module lcd_ctrl_param #(
  parameter int DW    = 8,
  parameter int IMG_W = 12,
  parameter int IMG_H = 8,
  parameter int WIN   = 4
) (
  input logic             clk,
  input logic             reset,
  lcd_ctrl_param_if.slave bus
);
  localparam int N     = WIN * WIN;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int SX    = IMG_W / WIN;
  localparam int SY    = IMG_H / WIN;
  localparam int BW    = $clog2(N);
  localparam int WW    = $clog2(WIN);
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int AW    = $clog2(TOTAL);
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [XW-1:0] X_MAX   = XW'(IMG_W - WIN);
  localparam logic [YW-1:0] Y_MAX   = YW'(IMG_H - WIN);
  localparam logic [XW-1:0] X_MID   = XW'((IMG_W - WIN) / 2);
  localparam logic [YW-1:0] Y_MID   = YW'((IMG_H - WIN) / 2);
  localparam logic [WW-1:0] W_LAST  = WW'(WIN - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(N - 1);
  localparam logic [BW-1:0] B_WIN   = BW'(WIN);
  localparam logic [CW-1:0] PIX_END = CW'(TOTAL);

  localparam logic [3:0] CMD_LOAD     = 4'd0;
  localparam logic [3:0] CMD_ROT_L    = 4'd1;
  localparam logic [3:0] CMD_ROT_R    = 4'd2;
  localparam logic [3:0] CMD_ZOOM_IN  = 4'd3;
  localparam logic [3:0] CMD_ZOOM_FIT = 4'd4;
  localparam logic [3:0] CMD_SHIFT_R  = 4'd5;
  localparam logic [3:0] CMD_SHIFT_L  = 4'd6;
  localparam logic [3:0] CMD_SHIFT_U  = 4'd7;
  localparam logic [3:0] CMD_SHIFT_D  = 4'd8;
  localparam logic [3:0] CMD_MIRROR   = 4'd9;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UPD, S_OUT, S_NOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pix_cnt;
  logic [BW-1:0] beat;
  logic          out_valid;
  logic [DW-1:0] dout;

  logic          zoom;
  logic [1:0]    rot;
  logic          mir;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;

  logic [DW-1:0] mem [TOTAL];

  logic          load_done;
  logic          accept;
  logic [BW-1:0] nxt_beat;
  logic [WW-1:0] bi, bj, jm, wr, wc;
  logic [YW-1:0] fr;
  logic [XW-1:0] fc;
  logic [AW-1:0] rd_addr;

  assign load_done = (state == S_LOAD) && (pix_cnt == PIX_END);
  assign accept    = bus.cmd_valid && (state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd == CMD_LOAD)         state_nxt = S_LOAD;
          else if (bus.cmd <= CMD_MIRROR)  state_nxt = S_UPD;
          else                             state_nxt = S_NOP;
        end
      end
      S_LOAD:  if (pix_cnt == PIX_END) state_nxt = S_UPD;
      S_UPD:   state_nxt = S_OUT;
      S_OUT:   if (beat == B_LAST) state_nxt = S_IDLE;
      S_NOP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // View state changes on the accept edge; a completed LOAD re-centres the fit view.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zoom <= 1'b0;
      rot  <= 2'd0;
      mir  <= 1'b0;
      x0   <= X_MID;
      y0   <= Y_MID;
    end else if (load_done) begin
      zoom <= 1'b0;
      rot  <= 2'd0;
      mir  <= 1'b0;
      x0   <= X_MID;
      y0   <= Y_MID;
    end else if (accept) begin
      case (bus.cmd)
        CMD_ROT_L:    rot  <= rot - 2'd1;
        CMD_ROT_R:    rot  <= rot + 2'd1;
        CMD_ZOOM_IN:  zoom <= 1'b1;
        CMD_ZOOM_FIT: zoom <= 1'b0;
        CMD_SHIFT_R:  if (zoom && x0 != X_MAX) x0 <= x0 + 1'b1;
        CMD_SHIFT_L:  if (zoom && x0 != '0)    x0 <= x0 - 1'b1;
        CMD_SHIFT_U:  if (zoom && y0 != '0)    y0 <= y0 - 1'b1;
        CMD_SHIFT_D:  if (zoom && y0 != Y_MAX) y0 <= y0 + 1'b1;
        CMD_MIRROR:   mir  <= ~mir;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               pix_cnt <= '0;
    else if (state == S_IDLE)                 pix_cnt <= '0;
    else if (state == S_LOAD && !load_done)   pix_cnt <= pix_cnt + 1'b1;
  end

  // Frame storage is deliberately not reset so an aborted operation keeps the loaded image.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && !load_done) mem[pix_cnt[AW-1:0]] <= bus.datain;
  end

  always_comb begin
    nxt_beat = (state == S_OUT) ? beat + 1'b1 : '0;
    bi       = WW'(nxt_beat / B_WIN);
    bj       = WW'(nxt_beat % B_WIN);
    jm       = mir ? W_LAST - bj : bj;
    wr       = bi;
    wc       = jm;
    case (rot)
      2'd1:    begin wr = W_LAST - jm; wc = bi;          end
      2'd2:    begin wr = W_LAST - bi; wc = W_LAST - jm; end
      2'd3:    begin wr = jm;          wc = W_LAST - bi; end
      default: begin wr = bi;          wc = jm;          end
    endcase
    if (zoom) begin
      fr = y0 + YW'(wr);
      fc = x0 + XW'(wc);
    end else begin
      fr = YW'(wr) * YW'(SY) + YW'(SY / 2);
      fc = XW'(wc) * XW'(SX) + XW'(SX / 2);
    end
    rd_addr = AW'(fr) * AW'(IMG_W) + AW'(fc);
  end

  // Each beat is registered one edge after it is addressed; dataout holds between bursts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat      <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      case (state)
        S_UPD: begin
          beat      <= '0;
          out_valid <= 1'b1;
          dout      <= mem[rd_addr];
        end
        S_OUT: begin
          if (beat == B_LAST) begin
            out_valid <= 1'b0;
          end else begin
            beat <= nxt_beat;
            dout <= mem[rd_addr];
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.output_valid = out_valid;
  assign bus.dataout      = dout;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param: a command table with expected burst heads,
// plus a reference model feeding a scoreboard queue that every output beat is checked against.
module tb_lcd_ctrl_param;
  localparam int DW    = 8;
  localparam int IMG_W = 12;
  localparam int IMG_H = 8;
  localparam int WIN   = 4;
  localparam int N     = WIN * WIN;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int SX    = IMG_W / WIN;
  localparam int SY    = IMG_H / WIN;

  typedef struct {
    logic [3:0] cmd;
    int         busy_len;
    int         beats;
    int         e0, e1, e2, e3;
  } vec_t;

  logic clk;
  logic reset;

  lcd_ctrl_param_if #(.DW(DW)) bus ();

  lcd_ctrl_param #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int got[$];
  int busy_run = 0;
  int last_busy = -1;
  int last_exp = 0;

  int frame[TOTAL];
  int m_zoom, m_rot, m_mir, m_x0, m_y0;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic modelResetView();
    m_zoom = 0;
    m_rot  = 0;
    m_mir  = 0;
    m_x0   = (IMG_W - WIN) / 2;
    m_y0   = (IMG_H - WIN) / 2;
  endtask

  function automatic int modelPix(input int k);
    int i, j, jm, r, c, row, col;
    i  = k / WIN;
    j  = k % WIN;
    jm = m_mir ? WIN - 1 - j : j;
    case (m_rot)
      1:       begin r = WIN - 1 - jm; c = i;            end
      2:       begin r = WIN - 1 - i;  c = WIN - 1 - jm; end
      3:       begin r = jm;           c = WIN - 1 - i;  end
      default: begin r = i;            c = jm;           end
    endcase
    if (m_zoom != 0) begin
      row = m_y0 + r;
      col = m_x0 + c;
    end else begin
      row = r * SY + SY / 2;
      col = c * SX + SX / 2;
    end
    return frame[row * IMG_W + col];
  endfunction

  task automatic modelCommand(input logic [3:0] c);
    case (c)
      4'd0: begin
        for (int p = 0; p < TOTAL; p++) frame[p] = p % 256;
        modelResetView();
      end
      4'd1: m_rot = (m_rot + 3) % 4;
      4'd2: m_rot = (m_rot + 1) % 4;
      4'd3: m_zoom = 1;
      4'd4: m_zoom = 0;
      4'd5: if (m_zoom != 0 && m_x0 < IMG_W - WIN) m_x0++;
      4'd6: if (m_zoom != 0 && m_x0 > 0) m_x0--;
      4'd7: if (m_zoom != 0 && m_y0 > 0) m_y0--;
      4'd8: if (m_zoom != 0 && m_y0 < IMG_H - WIN) m_y0++;
      4'd9: m_mir = 1 - m_mir;
      default: ;
    endcase
    if (c <= 4'd9) begin
      for (int k = 0; k < N; k++) exp_q.push_back(modelPix(k));
      last_exp = modelPix(N - 1);
    end
  endtask

  // Scoreboard side: every valid beat pops one expectation; busy run lengths are recorded.
  always @(posedge clk) begin
    #1;
    if (bus.busy === 1'b1) begin
      busy_run++;
    end else begin
      if (busy_run > 0) last_busy = busy_run;
      busy_run = 0;
    end
    if (bus.output_valid === 1'b1) begin
      got.push_back(int'(bus.dataout));
      if (exp_q.size() == 0) check("unexpected_beat", int'(bus.dataout), -1);
      else check($sformatf("beat%0d", got.size() - 1), int'(bus.dataout), exp_q.pop_front());
    end
  end

  task automatic waitIdle();
    int guard = 0;
    while (bus.busy !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check("idle_timeout", guard, 0);
  endtask

  task automatic applyStimulus(input logic [3:0] c);
    waitIdle();
    last_busy     = -1;
    got.delete();
    bus.cmd       = c;
    bus.cmd_valid = 1'b1;
    modelCommand(c);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (c == 4'd0) begin
      for (int p = 0; p < TOTAL; p++) begin
        bus.datain = 8'(p);
        @(negedge clk);
      end
    end
  endtask

  function automatic int pickE(input vec_t v, input int k);
    case (k)
      0:       return v.e0;
      1:       return v.e1;
      2:       return v.e2;
      default: return v.e3;
    endcase
  endfunction

  task automatic checkOutput(input vec_t v);
    waitIdle();
    @(negedge clk);
    check($sformatf("busy_len cmd%0d", v.cmd), last_busy, v.busy_len);
    check($sformatf("beat_count cmd%0d", v.cmd), got.size(), v.beats);
    if (v.beats > 0) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("head%0d cmd%0d", k, v.cmd), (got.size() > k) ? got[k] : -1, pickE(v, k));
      check("dataout_hold", int'(bus.dataout), last_exp);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic addVec(input logic [3:0] c, input int b, input int n,
                        input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.cmd = c; v.busy_len = b; v.beats = n;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t fitv, zinv;
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 4'd0;
    bus.datain    = '0;
    modelResetView();
    for (int p = 0; p < TOTAL; p++) frame[p] = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_valid", int'(bus.output_valid), 0);
    check("reset_dataout", int'(bus.dataout), 0);
    reset = 1'b1;
    @(negedge clk);

    addVec(4'd0, TOTAL + N + 2, N, 13, 16, 19, 22);
    addVec(4'd3, N + 1, N, 28, 29, 30, 31);
    addVec(4'd5, N + 1, N, 29, 30, 31, 32);
    addVec(4'd5, N + 1, N, 30, 31, 32, 33);
    addVec(4'd5, N + 1, N, 31, 32, 33, 34);
    addVec(4'd5, N + 1, N, 32, 33, 34, 35);
    addVec(4'd5, N + 1, N, 32, 33, 34, 35);
    addVec(4'd6, N + 1, N, 31, 32, 33, 34);
    addVec(4'd6, N + 1, N, 30, 31, 32, 33);
    addVec(4'd6, N + 1, N, 29, 30, 31, 32);
    addVec(4'd6, N + 1, N, 28, 29, 30, 31);
    addVec(4'd2, N + 1, N, 64, 52, 40, 28);
    addVec(4'd1, N + 1, N, 28, 29, 30, 31);
    addVec(4'd1, N + 1, N, 31, 43, 55, 67);
    addVec(4'd1, N + 1, N, 67, 66, 65, 64);
    addVec(4'd1, N + 1, N, 64, 52, 40, 28);
    addVec(4'd1, N + 1, N, 28, 29, 30, 31);
    addVec(4'd9, N + 1, N, 31, 30, 29, 28);
    addVec(4'd9, N + 1, N, 28, 29, 30, 31);
    addVec(4'd7, N + 1, N, 16, 17, 18, 19);
    addVec(4'd7, N + 1, N, 4, 5, 6, 7);
    addVec(4'd7, N + 1, N, 4, 5, 6, 7);
    addVec(4'd8, N + 1, N, 16, 17, 18, 19);
    addVec(4'd8, N + 1, N, 28, 29, 30, 31);
    addVec(4'd8, N + 1, N, 40, 41, 42, 43);
    addVec(4'd8, N + 1, N, 52, 53, 54, 55);
    addVec(4'd8, N + 1, N, 52, 53, 54, 55);
    addVec(4'd7, N + 1, N, 40, 41, 42, 43);
    addVec(4'd7, N + 1, N, 28, 29, 30, 31);
    addVec(4'd3, N + 1, N, 28, 29, 30, 31);
    addVec(4'd4, N + 1, N, 13, 16, 19, 22);
    addVec(4'd5, N + 1, N, 13, 16, 19, 22);
    addVec(4'd4, N + 1, N, 13, 16, 19, 22);
    addVec(4'd2, N + 1, N, 85, 61, 37, 13);
    addVec(4'd1, N + 1, N, 13, 16, 19, 22);
    addVec(4'd9, N + 1, N, 22, 19, 16, 13);
    addVec(4'd9, N + 1, N, 13, 16, 19, 22);
    addVec(4'd12, 1, 0, 0, 0, 0, 0);
    addVec(4'd15, 1, 0, 0, 0, 0, 0);

    foreach (vecs[idx]) begin
      applyStimulus(vecs[idx].cmd);
      checkOutput(vecs[idx]);
    end

    fitv = vecs[30];
    zinv = vecs[1];

    // Commands held through the whole burst, including the edge busy falls on, are dropped.
    applyStimulus(4'd4);
    bus.cmd       = 4'd9;
    bus.cmd_valid = 1'b1;
    repeat (N + 1) @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      check($sformatf("busy_after_fall%0d", t), int'(bus.busy), 0);
      @(negedge clk);
    end
    checkOutput(fitv);
    applyStimulus(4'd4);
    checkOutput(fitv);

    // Reset while beat 7 of a zoom burst is on the output; the frame must survive.
    applyStimulus(4'd3);
    repeat (8) @(negedge clk);
    check("beats_before_reset", got.size(), 8);
    reset = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_valid", int'(bus.output_valid), 0);
    check("abort_dataout", int'(bus.dataout), 0);
    exp_q.delete();
    modelResetView();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(4'd4);
    checkOutput(fitv);
    applyStimulus(4'd3);
    checkOutput(zinv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
